// File: rtl/jtag_tap_pkg.sv
// rtl/jtag_tap_pkg.sv - TAP state encodings, opcodes and DR select decode
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    ST_EX2DR = 4'h0,
    ST_EX1DR = 4'h1,
    ST_SHDR  = 4'h2,
    ST_PAUDR = 4'h3,
    ST_SELIR = 4'h4,
    ST_UPDDR = 4'h5,
    ST_CAPDR = 4'h6,
    ST_SELDR = 4'h7,
    ST_EX2IR = 4'h8,
    ST_EX1IR = 4'h9,
    ST_SHIR  = 4'hA,
    ST_PAUIR = 4'hB,
    ST_RTI   = 4'hC,
    ST_UPDIR = 4'hD,
    ST_CAPIR = 4'hE,
    ST_TLR   = 4'hF
  } tap_state_e;

  localparam logic [3:0] OP_EXTEST  = 4'h0;
  localparam logic [3:0] OP_SAMPLE  = 4'h1;
  localparam logic [3:0] OP_IDCODE  = 4'h2;
  localparam logic [3:0] OP_BYPASS  = 4'hF;
  localparam logic [3:0] IR_CAPTURE = 4'b0001;

  typedef enum logic [1:0] {
    DR_BSR    = 2'd0,
    DR_IDCODE = 2'd1,
    DR_BYPASS = 2'd2
  } dr_sel_e;

  // Unknown opcodes fall through to the bypass register.
  function automatic dr_sel_e decode_dr(input logic [3:0] instr);
    case (instr)
      OP_EXTEST, OP_SAMPLE: return DR_BSR;
      OP_IDCODE:            return DR_IDCODE;
      default:              return DR_BYPASS;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// rtl/jtag_tap_fsm.sv - 16-state TAP controller state register
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output tap_state_e tap_state
);

  tap_state_e state_q;
  tap_state_e state_d;

  // Standard TMS-driven transitions
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_TLR:   state_d = tms ? ST_TLR   : ST_RTI;
      ST_RTI:   state_d = tms ? ST_SELDR : ST_RTI;
      ST_SELDR: state_d = tms ? ST_SELIR : ST_CAPDR;
      ST_CAPDR: state_d = tms ? ST_EX1DR : ST_SHDR;
      ST_SHDR:  state_d = tms ? ST_EX1DR : ST_SHDR;
      ST_EX1DR: state_d = tms ? ST_UPDDR : ST_PAUDR;
      ST_PAUDR: state_d = tms ? ST_EX2DR : ST_PAUDR;
      ST_EX2DR: state_d = tms ? ST_UPDDR : ST_SHDR;
      ST_UPDDR: state_d = tms ? ST_SELDR : ST_RTI;
      ST_SELIR: state_d = tms ? ST_TLR   : ST_CAPIR;
      ST_CAPIR: state_d = tms ? ST_EX1IR : ST_SHIR;
      ST_SHIR:  state_d = tms ? ST_EX1IR : ST_SHIR;
      ST_EX1IR: state_d = tms ? ST_UPDIR : ST_PAUIR;
      ST_PAUIR: state_d = tms ? ST_EX2IR : ST_PAUIR;
      ST_EX2IR: state_d = tms ? ST_UPDIR : ST_SHIR;
      ST_UPDIR: state_d = tms ? ST_SELDR : ST_RTI;
      default:  state_d = ST_TLR;
    endcase
  end

  // State register, forced to Test-Logic-Reset by trst
  always_ff @(posedge tck or posedge trst) begin
    if (trst) state_q <= ST_TLR;
    else      state_q <= state_d;
  end

  assign tap_state = state_q;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// rtl/jtag_tap_ctrl.sv - TAP controller sequencing a DW_bc_3 boundary chain
module jtag_tap_ctrl
  import jtag_tap_pkg::*;
#(
  parameter int          IR_W       = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  input  logic       tdi,
  output logic       tdo,
  output logic       tdo_en,
  output logic       bsr_si,
  input  logic       bsr_so,
  output logic       shift_dr,
  output logic       capture_en,
  output logic       update_dr,
  output logic       mode,
  output logic [3:0] tap_state
);

  tap_state_e state;
  dr_sel_e    dr_sel;

  logic [IR_W-1:0] ir_shift_q, ir_shift_d;
  logic [IR_W-1:0] instr_q, instr_d;
  logic [31:0]     idcode_q, idcode_d;
  logic            bypass_q, bypass_d;
  logic            tdo_q, tdo_d;
  logic            tdo_en_q, tdo_en_d;
  logic            bsr_sel;

  jtag_tap_fsm u_fsm (
    .tck       (tck),
    .trst      (trst),
    .tms       (tms),
    .tap_state (state)
  );

  assign dr_sel  = decode_dr(instr_q);
  assign bsr_sel = (dr_sel == DR_BSR);

  // Next values for IR, instruction latch and the internal DRs
  always_comb begin
    ir_shift_d = ir_shift_q;
    instr_d    = instr_q;
    idcode_d   = idcode_q;
    bypass_d   = bypass_q;

    if (state == ST_CAPIR) ir_shift_d = IR_CAPTURE;
    if (state == ST_SHIR)  ir_shift_d = {tdi, ir_shift_q[IR_W-1:1]};

    if (state == ST_UPDIR) instr_d = ir_shift_q;
    // Entering or sitting in TLR (only reachable from SelIR or TLR itself)
    if (state == ST_TLR || (state == ST_SELIR && tms)) instr_d = OP_IDCODE;

    if (dr_sel == DR_IDCODE) begin
      if (state == ST_CAPDR) idcode_d = IDCODE_VAL;
      if (state == ST_SHDR)  idcode_d = {tdi, idcode_q[31:1]};
    end
    if (dr_sel == DR_BYPASS) begin
      if (state == ST_CAPDR) bypass_d = 1'b0;
      if (state == ST_SHDR)  bypass_d = tdi;
    end
  end

  // Rising-edge data registers
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      ir_shift_q <= IR_CAPTURE;
      instr_q    <= OP_IDCODE;
      idcode_q   <= IDCODE_VAL;
      bypass_q   <= 1'b0;
    end else begin
      ir_shift_q <= ir_shift_d;
      instr_q    <= instr_d;
      idcode_q   <= idcode_d;
      bypass_q   <= bypass_d;
    end
  end

  // TDO source select; holds its last value outside the shift states
  always_comb begin
    tdo_d    = tdo_q;
    tdo_en_d = (state == ST_SHIR) || (state == ST_SHDR);
    if (state == ST_SHIR) begin
      tdo_d = ir_shift_q[0];
    end else if (state == ST_SHDR) begin
      case (dr_sel)
        DR_BSR:    tdo_d = bsr_so;
        DR_IDCODE: tdo_d = idcode_q[0];
        default:   tdo_d = bypass_q;
      endcase
    end
  end

  // TDO launched on falling tck so it is stable at the next rising edge
  always_ff @(negedge tck or posedge trst) begin
    if (trst) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign tdo        = tdo_q;
  assign tdo_en     = tdo_en_q;
  assign bsr_si     = tdi;
  assign shift_dr   = bsr_sel && (state == ST_SHDR);
  assign capture_en = !(bsr_sel && (state == ST_CAPDR || state == ST_SHDR));
  assign update_dr  = (state == ST_UPDDR);
  assign mode       = (instr_q == OP_EXTEST);
  assign tap_state  = state;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb/tb_jtag_tap_ctrl.sv - randomized self-checking bench for jtag_tap_ctrl
module tb_jtag_tap_ctrl;

  logic       tck;
  logic       trst;
  logic       tms;
  logic       tdi;
  logic       tdo;
  logic       tdo_en;
  logic       bsr_si;
  logic       bsr_so;
  logic       shift_dr;
  logic       capture_en;
  logic       update_dr;
  logic       mode;
  logic [3:0] tap_state;

  int n_checks = 0;
  int n_fail   = 0;

  jtag_tap_ctrl dut (
    .tck        (tck),
    .trst       (trst),
    .tms        (tms),
    .tdi        (tdi),
    .tdo        (tdo),
    .tdo_en     (tdo_en),
    .bsr_si     (bsr_si),
    .bsr_so     (bsr_so),
    .shift_dr   (shift_dr),
    .capture_en (capture_en),
    .update_dr  (update_dr),
    .mode       (mode),
    .tap_state  (tap_state)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: named states, separate encoding table
  typedef enum int {
    M_TLR, M_RTI,
    M_SELDR, M_CAPDR, M_SHDR, M_EX1DR, M_PAUDR, M_EX2DR, M_UPDDR,
    M_SELIR, M_CAPIR, M_SHIR, M_EX1IR, M_PAUIR, M_EX2IR, M_UPDIR
  } mstate_e;

  mstate_e m_state;
  int      m_instr;
  bit      m_ir[$];
  bit      m_dr[$];
  logic    m_tdo;
  logic    m_tdo_en;

  function automatic mstate_e nxt(input mstate_e s, input bit t);
    case (s)
      M_TLR:   return t ? M_TLR   : M_RTI;
      M_RTI:   return t ? M_SELDR : M_RTI;
      M_SELDR: return t ? M_SELIR : M_CAPDR;
      M_CAPDR: return t ? M_EX1DR : M_SHDR;
      M_SHDR:  return t ? M_EX1DR : M_SHDR;
      M_EX1DR: return t ? M_UPDDR : M_PAUDR;
      M_PAUDR: return t ? M_EX2DR : M_PAUDR;
      M_EX2DR: return t ? M_UPDDR : M_SHDR;
      M_UPDDR: return t ? M_SELDR : M_RTI;
      M_SELIR: return t ? M_TLR   : M_CAPIR;
      M_CAPIR: return t ? M_EX1IR : M_SHIR;
      M_SHIR:  return t ? M_EX1IR : M_SHIR;
      M_EX1IR: return t ? M_UPDIR : M_PAUIR;
      M_PAUIR: return t ? M_EX2IR : M_PAUIR;
      M_EX2IR: return t ? M_UPDIR : M_SHIR;
      default: return t ? M_SELDR : M_RTI;
    endcase
  endfunction

  function automatic logic [3:0] code_of(input mstate_e s);
    case (s)
      M_TLR:   return 4'hF;  M_RTI:   return 4'hC;
      M_SELDR: return 4'h7;  M_CAPDR: return 4'h6;
      M_SHDR:  return 4'h2;  M_EX1DR: return 4'h1;
      M_PAUDR: return 4'h3;  M_EX2DR: return 4'h0;
      M_UPDDR: return 4'h5;  M_SELIR: return 4'h4;
      M_CAPIR: return 4'hE;  M_SHIR:  return 4'hA;
      M_EX1IR: return 4'h9;  M_PAUIR: return 4'hB;
      M_EX2IR: return 4'h8;  default: return 4'hD;
    endcase
  endfunction

  task automatic model_reset();
    m_state = M_TLR;
    m_instr = 2;
    m_ir.delete();
    m_ir.push_back(1'b1);
    for (int i = 0; i < 3; i++) m_ir.push_back(1'b0);
    m_dr.delete();
    m_tdo    = 1'b0;
    m_tdo_en = 1'b0;
  endtask

  // One tck period: drive, advance model on rise, compare after rise and fall
  task automatic step(input bit t, input bit d);
    bit      bsr;
    mstate_e ms;
    int      v;
    tms    = t;
    tdi    = d;
    bsr_so = 1'($urandom_range(0, 1));
    @(posedge tck);
    ms  = m_state;
    bsr = (m_instr == 0) || (m_instr == 1);
    if (ms == M_CAPIR) begin
      m_ir.delete();
      m_ir.push_back(1'b1);
      for (int i = 0; i < 3; i++) m_ir.push_back(1'b0);
    end
    if (ms == M_SHIR) begin
      void'(m_ir.pop_front());
      m_ir.push_back(d);
    end
    if (ms == M_UPDIR) begin
      v = 0;
      for (int i = 0; i < 4; i++) v += int'(m_ir[i]) << i;
      m_instr = v;
    end
    if (ms == M_CAPDR && !bsr) begin
      m_dr.delete();
      if (m_instr == 2) for (int i = 0; i < 32; i++) m_dr.push_back(bit'(32'h1000_0001 >> i));
      else m_dr.push_back(1'b0);
    end
    if (ms == M_SHDR && !bsr && m_dr.size() > 0) begin
      void'(m_dr.pop_front());
      m_dr.push_back(d);
    end
    m_state = nxt(ms, t);
    if (m_state == M_TLR) m_instr = 2;
    bsr = (m_instr == 0) || (m_instr == 1);
    #1;
    n_checks++;
    if (tap_state !== code_of(m_state)) begin
      n_fail++;
      $display("FAIL step_tap_state: got %h expected %h", tap_state, code_of(m_state));
    end
    n_checks++;
    if (shift_dr !== (m_state == M_SHDR && bsr)) begin
      n_fail++;
      $display("FAIL step_shift_dr: got %b expected %b", shift_dr, (m_state == M_SHDR && bsr));
    end
    n_checks++;
    if (capture_en !== !((m_state == M_CAPDR || m_state == M_SHDR) && bsr)) begin
      n_fail++;
      $display("FAIL step_capture_en: got %b expected %b", capture_en,
               !((m_state == M_CAPDR || m_state == M_SHDR) && bsr));
    end
    n_checks++;
    if (update_dr !== (m_state == M_UPDDR)) begin
      n_fail++;
      $display("FAIL step_update_dr: got %b expected %b", update_dr, (m_state == M_UPDDR));
    end
    n_checks++;
    if (mode !== (m_instr == 0)) begin
      n_fail++;
      $display("FAIL step_mode: got %b expected %b", mode, (m_instr == 0));
    end
    n_checks++;
    if (bsr_si !== tdi) begin
      n_fail++;
      $display("FAIL step_bsr_si: got %b expected %b", bsr_si, tdi);
    end
    @(negedge tck);
    if (m_state == M_SHIR) m_tdo = m_ir[0];
    else if (m_state == M_SHDR) m_tdo = bsr ? bsr_so : (m_dr.size() > 0 ? m_dr[0] : 1'bx);
    m_tdo_en = (m_state == M_SHIR) || (m_state == M_SHDR);
    #1;
    n_checks++;
    if (tdo !== m_tdo || tdo_en !== m_tdo_en) begin
      n_fail++;
      $display("FAIL step_tdo: got tdo=%b en=%b expected tdo=%b en=%b", tdo, tdo_en, m_tdo, m_tdo_en);
    end
  endtask

  // From RTI: scan an opcode into IR and return to RTI
  task automatic load_ir(input logic [3:0] v);
    step(1, 1'($urandom));
    step(1, 1'($urandom));
    step(0, 1'($urandom));
    step(0, 1'($urandom));
    for (int i = 0; i < 4; i++) step(i == 3, v[i]);
    step(1, 1'($urandom));
    step(0, 1'($urandom));
  endtask

  task automatic test_reset();
    trst = 1'b1; tms = 1'b1; tdi = 1'b0; bsr_so = 1'b0;
    model_reset();
    #2;
    n_checks++;
    if (tap_state !== 4'hF || tdo !== 1'b0 || tdo_en !== 1'b0 || shift_dr !== 1'b0 ||
        capture_en !== 1'b1 || update_dr !== 1'b0 || mode !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: got st=%h tdo=%b en=%b sd=%b ce=%b ud=%b mode=%b required F 0 0 0 1 0 0",
               tap_state, tdo, tdo_en, shift_dr, capture_en, update_dr, mode);
    end
    @(posedge tck); @(negedge tck); #1;
    trst = 1'b0;
    step(0, 0);
    n_checks++;
    if (tap_state !== 4'hC) begin
      n_fail++;
      $display("FAIL reset_first_edge: got %h required C", tap_state);
    end
    load_ir(4'h0);
    step(1, 0); step(0, 0); step(0, 1);
    step(0, 1); step(0, 0);
    trst = 1'b1;
    #2;
    n_checks++;
    if (tap_state !== 4'hF || capture_en !== 1'b1 || shift_dr !== 1'b0 || mode !== 1'b0 || tdo_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_shdr: got st=%h ce=%b sd=%b mode=%b en=%b required F 1 0 0 0",
               tap_state, capture_en, shift_dr, mode, tdo_en);
    end
    model_reset();
    @(posedge tck); @(negedge tck); #1;
    trst = 1'b0;
    step(0, 0);
  endtask

  task automatic test_tlr_recovery();
    for (int i = 0; i < 5; i++) step(1, 1'($urandom));
    n_checks++;
    if (tap_state !== 4'hF) begin
      n_fail++;
      $display("FAIL tlr_from_rti: got %h required F", tap_state);
    end
    step(0, 0); step(1, 0); step(1, 0); step(0, 0); step(0, 1); step(1, 0); step(0, 0);
    for (int i = 0; i < 5; i++) step(1, 1'($urandom));
    n_checks++;
    if (tap_state !== 4'hF) begin
      n_fail++;
      $display("FAIL tlr_from_pauir: got %h required F", tap_state);
    end
    step(0, 0); step(1, 0); step(0, 0); step(0, 0); step(0, 1);
    for (int i = 0; i < 5; i++) step(1, 1'($urandom));
    n_checks++;
    if (tap_state !== 4'hF || mode !== 1'b0) begin
      n_fail++;
      $display("FAIL tlr_from_shdr: got st=%h mode=%b required F 0", tap_state, mode);
    end
    step(0, 0);
  endtask

  task automatic test_idcode();
    logic [31:0] got;
    step(1, 0); step(0, 0); step(0, 0);
    got[0] = tdo;
    for (int i = 1; i < 32; i++) begin
      step(0, 1'($urandom));
      got[i] = tdo;
    end
    step(1, 0); step(1, 0); step(0, 0);
    n_checks++;
    if (got !== 32'h1000_0001) begin
      n_fail++;
      $display("FAIL idcode_read: got %h required 10000001", got);
    end
  endtask

  task automatic test_ir_extest();
    logic [3:0] got;
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    got[0] = tdo;
    for (int i = 0; i < 4; i++) begin
      step(i == 3, 0);
      if (i < 3) got[i+1] = tdo;
    end
    n_checks++;
    if (got !== 4'b0001) begin
      n_fail++;
      $display("FAIL ir_capture: got bits(lsb first)=%b required 0001", got);
    end
    step(1, 0); step(0, 0);
    n_checks++;
    if (mode !== 1'b1) begin
      n_fail++;
      $display("FAIL ir_extest_mode: got %b required 1", mode);
    end
  endtask

  task automatic test_extest_dr();
    step(1, 0); step(0, 0);
    n_checks++;
    if (capture_en !== 1'b0 || shift_dr !== 1'b0) begin
      n_fail++;
      $display("FAIL extest_capdr: got ce=%b sd=%b required 0 0", capture_en, shift_dr);
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 1'($urandom));
      n_checks++;
      if (capture_en !== 1'b0 || shift_dr !== 1'b1 || tdo !== bsr_so) begin
        n_fail++;
        $display("FAIL extest_shdr: got ce=%b sd=%b tdo=%b required 0 1 tdo=%b", capture_en, shift_dr, tdo, bsr_so);
      end
    end
    step(1, 0); step(0, 0);
    n_checks++;
    if (capture_en !== 1'b1 || shift_dr !== 1'b0) begin
      n_fail++;
      $display("FAIL extest_paudr: got ce=%b sd=%b required 1 0", capture_en, shift_dr);
    end
    step(1, 0); step(1, 0);
    n_checks++;
    if (update_dr !== 1'b1) begin
      n_fail++;
      $display("FAIL extest_upddr: got %b required 1", update_dr);
    end
    step(0, 0);
    n_checks++;
    if (update_dr !== 1'b0) begin
      n_fail++;
      $display("FAIL extest_upddr_one_cycle: got %b required 0", update_dr);
    end
  endtask

  task automatic test_bypass();
    logic [2:0] got;
    load_ir(4'h7);
    step(1, 0); step(0, 0); step(0, 1);
    got[0] = tdo;
    n_checks++;
    if (mode !== 1'b0 || shift_dr !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_controls: got mode=%b sd=%b required 0 0", mode, shift_dr);
    end
    step(0, 1); got[1] = tdo;
    step(0, 0); got[2] = tdo;
    step(1, 1); step(1, 0); step(0, 0);
    n_checks++;
    if (got !== 3'b010) begin
      n_fail++;
      $display("FAIL bypass_shift: got bits(first at lsb)=%b required 010", got);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        trst = 1'b1;
        model_reset();
        #2;
        n_checks++;
        if (tap_state !== 4'hF || tdo_en !== 1'b0 || mode !== 1'b0) begin
          n_fail++;
          $display("FAIL random_async_reset: got st=%h en=%b mode=%b required F 0 0", tap_state, tdo_en, mode);
        end
        @(posedge tck); @(negedge tck); #1;
        trst = 1'b0;
      end else begin
        step(1'($urandom_range(0, 99) < 35), 1'($urandom));
      end
    end
  endtask

  initial begin
    test_reset();
    test_tlr_recovery();
    test_idcode();
    test_ir_extest();
    test_extest_dr();
    test_bypass();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_tap_ctrl.md
# jtag_tap_ctrl

IEEE 1149.1 TAP controller that drives the boundary-scan chain of input cells built from `DW_bc_3`. It decodes TMS into the 16-state TAP FSM and holds a 4-bit instruction register. It generates the `shift_dr`, `capture_en` (active-low) and `mode` controls for the chain, and muxes BSR, BYPASS, IDCODE and IR data onto TDO. It sits directly upstream of the boundary cells: its `tck` is the cells' `capture_clk`, and its `bsr_si`/`bsr_so` close the chain.

## Interface
- `IR_W`, default 4: instruction register width; fixed at 4, encodings below depend on it.
- `IDCODE_VAL`, default 32'h1000_0001: IDCODE register content; bit 0 must be 1.
- `tck` input 1: the single clock; test clock, also routed to the cells' `capture_clk`.
- `trst` input 1: reset, asynchronous, active-high.
- `tms` input 1: test mode select, sampled on rising `tck`.
- `tdi` input 1: test data in, sampled on rising `tck`.
- `tdo` output 1: test data out, updated on falling `tck`.
- `tdo_en` output 1: high while the FSM is in Shift-DR or Shift-IR (registered on falling `tck`).
- `bsr_si` output 1: serial in to the first boundary cell; equals `tdi`.
- `bsr_so` input 1: serial out from the last boundary cell.
- `shift_dr` output 1: to the cells; high in Shift-DR when the BSR is selected.
- `capture_en` output 1: to the cells, active-low; 0 in Capture-DR or Shift-DR when the BSR is selected, else 1.
- `update_dr` output 1: high for the one cycle spent in Update-DR, for any selected DR.
- `mode` output 1: to the cells; 1 while IR holds EXTEST.
- `tap_state` output 4: current FSM state encoding, for debug.

## Operation
- **FSM:** the 16 standard states with standard TMS transitions:
  - TLR, RTI
  - SelDR, CapDR, ShDR, Ex1DR, PauDR, Ex2DR, UpdDR
  - SelIR, CapIR, ShIR, Ex1IR, PauIR, Ex2IR, UpdIR
- **Encodings:** shared package constants, TLR=4'hF, RTI=4'hC.
- **TLR recovery:** five consecutive `tms`=1 cycles reach TLR from any state.
- **Instructions:**
  - EXTEST=4'h0 selects the BSR, `mode`=1.
  - SAMPLE=4'h1 selects the BSR, `mode`=0.
  - IDCODE=4'h2 selects the 32-bit IDCODE register.
  - BYPASS=4'hF selects the 1-bit bypass register.
  - Any other code decodes as BYPASS.
- **IR:**
  - Shift register loads 4'b0001 in CapIR.
  - Shifts LSB-first in ShIR, `tdi` entering at the MSB.
  - Copied to the instruction latch on the rising edge that leaves UpdIR.
- **Instruction latch reset:** IDCODE, by `trst` or on entry to TLR.
- **IDCODE register:** loads `IDCODE_VAL` in CapDR, shifts right in ShDR with `tdi` into bit 31.
- **Bypass register:** loads 0 in CapDR, loads `tdi` in ShDR.
- **TDO mux:** in ShIR: IR LSB; in ShDR: selected DR LSB (`bsr_so` for the BSR); else hold last value with `tdo_en`=0.
- **`bsr_si`:** is `tdi` combinationally.
- **BSR shifting:** the cells do their own capture/shift on `tck` from `shift_dr`/`capture_en`. This block only sequences them.

## Timing
- FSM, IR shift register, DRs and instruction latch update on rising `tck`.
- `tdo` and `tdo_en` update on falling `tck`, from registered state/data.
- `shift_dr`, `capture_en`, `update_dr` and `mode` are decoded combinationally from the state register and instruction latch only, never from `tms`.
- `shift_dr`/`capture_en` are asserted during the cycle the FSM occupies ShDR/CapDR. The cells therefore act on the rising edge that ends that state.
- **Reset** (asynchronous on `trst` rise, held while high):
  - state=TLR, instruction=IDCODE, IR shift=4'b0001, bypass=0, IDCODE shift=`IDCODE_VAL`.
  - `tdo`=0, `tdo_en`=0, `shift_dr`=0, `capture_en`=1, `update_dr`=0, `mode`=0.
- **Reset mid-shift:** discards partial IR/DR data; instruction becomes IDCODE.
- **First edge after release:** the first rising `tck` after `trst` falls evaluates `tms` normally.
- **Pause/Exit states:** hold all shift registers; `shift_dr`=0, `capture_en`=1 (cells hold).
- **Changing `mode`:** `mode` changes only when leaving UpdIR or on reset/TLR entry.

## Structure
- **Package `jtag_tap_pkg`:** state encoding constants, instruction opcodes (EXTEST, SAMPLE, IDCODE, BYPASS), IR capture value 4'b0001.
- **Sub-module `jtag_tap_fsm`:** state register plus next-state logic (`tck`, `trst`, `tms` in; `tap_state` out).
- **Top-level logic:** IR, DRs, decode and TDO mux live in `jtag_tap_ctrl`.

## Test plan
- **Async reset:** assert `trst` mid-ShDR → `tap_state`=4'hF immediately, `capture_en`=1, `shift_dr`=0, `mode`=0, `tdo_en`=0.
- **TLR recovery:** from RTI, `tms`=1 for 5 cycles → TLR. Also from PauIR and ShDR.
- **IDCODE read:** after reset, TLR→RTI→SelDR→CapDR→ShDR then 32 shifts → `tdo` streams 32'h1000_0001 LSB-first, first bit 1.
- **IR capture/load:** shift IR with `tdi`=0,0,0,0 → `tdo` yields 1,0,0,0. After UpdIR → `mode`=1 (EXTEST).
- **EXTEST DR sequence:** CapDR → `capture_en`=0, `shift_dr`=0. ShDR → `capture_en`=0, `shift_dr`=1, `tdo` follows `bsr_so`. PauDR → `capture_en`=1. UpdDR → `update_dr`=1 for exactly one cycle.
- **Undefined opcode / BYPASS:** load IR=4'h7 then shift DR with `tdi`=1,0,1 → `tdo` yields 0,1,0 (one-cycle delay); `mode`=0, `shift_dr`=0.
